// File: rtl/iq_issue_select.sv
// Issue-queue read side: picks the oldest ready entry by robid age and holds its
// payload in a one-deep output register that drains to the FU over valid/ready.
module iq_issue_select #(
  parameter int NUM_ENTRIES = 8,
  parameter int ROBID_W     = 7,
  parameter int PAYLOAD_W   = 256,
  localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [NUM_ENTRIES-1:0]         ent_ready,
  input  logic [NUM_ENTRIES*ROBID_W-1:0] ent_robid,
  input  logic [NUM_ENTRIES*PAYLOAD_W-1:0] ent_payload,
  output logic [NUM_ENTRIES-1:0]         issuing,
  output logic                           issue_valid,
  input  logic                           issue_ready,
  output logic [ROBID_W-1:0]             issue_robid,
  output logic [PAYLOAD_W-1:0]           issue_payload,
  output logic [IDX_W-1:0]               issue_idx,
  output logic [31:0]                    perf_issue_cnt
);

  // Robids carry a wrap flag in the MSB; differing flags invert the index order.
  function automatic logic is_older(input logic [ROBID_W-1:0] a, input logic [ROBID_W-1:0] b);
    logic res;
    if (a[ROBID_W-1] == b[ROBID_W-1]) begin
      res = (a[ROBID_W-2:0] < b[ROBID_W-2:0]);
    end else begin
      res = (a[ROBID_W-2:0] > b[ROBID_W-2:0]);
    end
    return res;
  endfunction

  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic [ROBID_W-1:0]    sel_robid;
  logic [PAYLOAD_W-1:0]  sel_payload;
  logic                  load_en;
  logic                  issue_fire;

  // Oldest-ready scan; only a strictly older entry displaces the current pick,
  // so equal robids resolve to the lowest index.
  always_comb begin
    logic take;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_robid = '0;
    take      = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      take      = ent_ready[i] &
                  (~sel_found | is_older(ent_robid[i*ROBID_W +: ROBID_W], sel_robid));
      sel_found = sel_found | take;
      sel_idx   = take ? IDX_W'(i) : sel_idx;
      sel_robid = take ? ent_robid[i*ROBID_W +: ROBID_W] : sel_robid;
    end
  end

  // Payload of the selected entry.
  always_comb begin
    sel_payload = ent_payload[sel_idx*PAYLOAD_W +: PAYLOAD_W];
  end

  // Select pulse: register free or draining, no flush, and not held in reset.
  always_comb begin
    load_en    = (~issue_valid | issue_ready) & ~flush & ~reset;
    issue_fire = load_en & sel_found;
    if (issue_fire) begin
      issuing = {{(NUM_ENTRIES-1){1'b0}}, 1'b1} << sel_idx;
    end else begin
      issuing = '0;
    end
  end

  // Output register: flush kills it; otherwise it reloads whenever load_en is set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_valid   <= 1'b0;
      issue_robid   <= '0;
      issue_payload <= '0;
      issue_idx     <= '0;
    end else if (flush) begin
      issue_valid   <= 1'b0;
    end else if (load_en) begin
      issue_valid   <= sel_found;
      if (sel_found) begin
        issue_robid   <= sel_robid;
        issue_payload <= sel_payload;
        issue_idx     <= sel_idx;
      end
    end
  end

  // Completed-handshake counter; flush does not clear it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_issue_cnt <= 32'd0;
    end else if (issue_valid & issue_ready) begin
      perf_issue_cnt <= perf_issue_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_iq_issue_select.sv
// Self-checking bench for iq_issue_select: selection table, stall/flush/reset
// sequences and a streaming run, with a scoreboard on the output register.
module tb_iq_issue_select;
  localparam int N  = 8;
  localparam int RW = 7;
  localparam int PW = 256;
  localparam int IW = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            flush;
  logic            issue_ready;
  logic [N-1:0]    ent_ready;
  logic [N*RW-1:0] ent_robid;
  logic [N*PW-1:0] ent_payload;
  logic [N-1:0]    issuing;
  logic            issue_valid;
  logic [RW-1:0]   issue_robid;
  logic [PW-1:0]   issue_payload;
  logic [IW-1:0]   issue_idx;
  logic [31:0]     perf_issue_cnt;

  iq_issue_select #(.NUM_ENTRIES(N), .ROBID_W(RW), .PAYLOAD_W(PW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .ent_ready(ent_ready), .ent_robid(ent_robid), .ent_payload(ent_payload),
    .issuing(issuing), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_robid(issue_robid), .issue_payload(issue_payload),
    .issue_idx(issue_idx), .perf_issue_cnt(perf_issue_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [RW-1:0] rob;
    logic [PW-1:0] pay;
    logic [IW-1:0] idx;
  } item_t;

  typedef struct packed {
    logic [N-1:0]    rdy;
    logic [N*RW-1:0] robs;
    logic [N-1:0]    exp_iss;
    logic            exp_vld;
    logic [IW-1:0]   exp_idx;
    logic [RW-1:0]   exp_rob;
  } vec_t;

  item_t       sb_q[$];
  vec_t        vecs[8];
  int          checks = 0;
  int          errors = 0;
  bit          mvalid;
  logic [31:0] mcnt;
  logic [31:0] cnt_before;
  logic [N-1:0] exp_iss;

  function automatic logic older(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return (a[RW-1] == b[RW-1]) ? (a[RW-2:0] < b[RW-2:0]) : (a[RW-2:0] > b[RW-2:0]);
  endfunction

  function automatic logic [PW-1:0] mkpay(input int i, input logic [RW-1:0] r);
    logic [31:0] w;
    w = 32'hA5A5_0000 | (32'(i) << 8) | 32'(r);
    return {w, ~w, w + 32'd1, w ^ 32'h0F0F_0F0F, w, ~w, w + 32'd2, w ^ 32'hF0F0_F0F0};
  endfunction

  function automatic logic [RW-1:0] rob_of(input int i);
    return ent_robid[i*RW +: RW];
  endfunction

  // Winner = ready entry that no other ready entry beats (older, or equal at lower index).
  function automatic logic [N-1:0] model_pick();
    logic [N-1:0] res;
    bit beaten;
    res = '0;
    for (int i = 0; i < N; i++) begin
      if (ent_ready[i]) begin
        beaten = 1'b0;
        for (int j = 0; j < N; j++) begin
          if (j != i && ent_ready[j] &&
              (older(rob_of(j), rob_of(i)) || (j < i && rob_of(j) == rob_of(i))))
            beaten = 1'b1;
        end
        if (!beaten) res[i] = 1'b1;
      end
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ent(input int i, input logic rdy, input logic [RW-1:0] r);
    ent_ready[i]            = rdy;
    ent_robid[i*RW +: RW]   = r;
    ent_payload[i*PW +: PW] = mkpay(i, r);
  endtask

  task automatic clear_ents();
    for (int i = 0; i < N; i++) set_ent(i, 1'b0, 7'h00);
  endtask

  // One clock: check the select pulse and held output against the model, then
  // advance the model across the edge (entry drops its ready when issued).
  task automatic cycle();
    logic [N-1:0] win;
    logic load, xfer;
    item_t it;
    #2;
    load = (!mvalid || issue_ready) && !flush;
    win  = load ? model_pick() : '0;
    check("issuing", issuing, win);
    check("issue_valid", issue_valid, mvalid);
    if (mvalid && sb_q.size() > 0) begin
      check("issue_robid", issue_robid, sb_q[0].rob);
      check("issue_payload", issue_payload, sb_q[0].pay);
      check("issue_idx", issue_idx, sb_q[0].idx);
    end else if (mvalid) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected a held item");
    end
    xfer = mvalid && issue_ready;
    @(posedge clock);
    #1;
    if (xfer && sb_q.size() > 0) it = sb_q.pop_front();
    if (xfer) mcnt = mcnt + 32'd1;
    if (flush) begin
      if (mvalid && !xfer && sb_q.size() > 0) it = sb_q.pop_front();
      mvalid = 1'b0;
    end else if (load) begin
      mvalid = (win != '0);
      for (int w = 0; w < N; w++) begin
        if (win[w]) begin
          it.rob = rob_of(w);
          it.pay = ent_payload[w*PW +: PW];
          it.idx = IW'(w);
          sb_q.push_back(it);
          ent_ready[w] = 1'b0;
        end
      end
    end
    check("perf_issue_cnt", perf_issue_cnt, mcnt);
  endtask

  initial begin
    vecs[0] = '{rdy: 8'h06, robs: {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h03, 7'h05, 7'h00},
                exp_iss: 8'h04, exp_vld: 1'b1, exp_idx: 3'd2, exp_rob: 7'h03};
    vecs[1] = '{rdy: 8'h81, robs: {7'h3E, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h41},
                exp_iss: 8'h80, exp_vld: 1'b1, exp_idx: 3'd7, exp_rob: 7'h3E};
    vecs[2] = '{rdy: 8'h28, robs: {7'h00, 7'h00, 7'h10, 7'h00, 7'h10, 7'h00, 7'h00, 7'h00},
                exp_iss: 8'h08, exp_vld: 1'b1, exp_idx: 3'd3, exp_rob: 7'h10};
    vecs[3] = '{rdy: 8'h00, robs: {7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h08},
                exp_iss: 8'h00, exp_vld: 1'b0, exp_idx: 3'd0, exp_rob: 7'h00};
    vecs[4] = '{rdy: 8'hFF, robs: {7'h19, 7'h1A, 7'h1B, 7'h1C, 7'h1D, 7'h1E, 7'h1F, 7'h20},
                exp_iss: 8'h80, exp_vld: 1'b1, exp_idx: 3'd7, exp_rob: 7'h19};
    vecs[5] = '{rdy: 8'h40, robs: {7'h00, 7'h33, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
                exp_iss: 8'h40, exp_vld: 1'b1, exp_idx: 3'd6, exp_rob: 7'h33};
    vecs[6] = '{rdy: 8'h03, robs: {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h7F, 7'h02},
                exp_iss: 8'h02, exp_vld: 1'b1, exp_idx: 3'd1, exp_rob: 7'h7F};
    vecs[7] = '{rdy: 8'h0C, robs: {7'h00, 7'h00, 7'h00, 7'h00, 7'h06, 7'h08, 7'h00, 7'h01},
                exp_iss: 8'h08, exp_vld: 1'b1, exp_idx: 3'd3, exp_rob: 7'h06};

    reset = 1'b1;
    flush = 1'b0;
    issue_ready = 1'b1;
    mvalid = 1'b0;
    mcnt = 32'd0;
    for (int i = 0; i < N; i++) set_ent(i, 1'b1, RW'(i));
    @(posedge clock);
    #1;
    check("rst_valid", issue_valid, 1'b0);
    check("rst_issuing", issuing, 8'h00);
    check("rst_cnt", perf_issue_cnt, 32'd0);
    check("rst_robid", issue_robid, 7'h00);
    check("rst_payload", issue_payload, '0);
    check("rst_idx", issue_idx, 3'd0);
    clear_ents();
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      clear_ents();
      for (int i = 0; i < N; i++) set_ent(i, vecs[v].rdy[i], vecs[v].robs[i*RW +: RW]);
      #1;
      check("vec_issuing", issuing, vecs[v].exp_iss);
      cycle();
      check("vec_valid", issue_valid, vecs[v].exp_vld);
      if (vecs[v].exp_vld) begin
        check("vec_idx", issue_idx, vecs[v].exp_idx);
        check("vec_robid", issue_robid, vecs[v].exp_rob);
      end
    end

    // Stall: held output, ready entry waits until the register frees.
    clear_ents();
    set_ent(0, 1'b1, 7'h01);
    cycle();
    issue_ready = 1'b0;
    set_ent(4, 1'b1, 7'h02);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_issuing", issuing, 8'h00);
      check("stall_robid", issue_robid, 7'h01);
      cycle();
    end
    issue_ready = 1'b1;
    cnt_before = mcnt;
    #1;
    check("unstall_issuing", issuing, 8'h10);
    cycle();
    check("unstall_cnt", perf_issue_cnt, cnt_before + 32'd1);

    // Flush while stalled with a ready entry.
    issue_ready = 1'b0;
    set_ent(3, 1'b1, 7'h04);
    flush = 1'b1;
    cnt_before = mcnt;
    #1;
    check("flush_issuing", issuing, 8'h00);
    cycle();
    flush = 1'b0;
    check("flush_valid", issue_valid, 1'b0);
    check("flush_cnt", perf_issue_cnt, cnt_before);

    // Asynchronous reset in the middle of a held instruction.
    cycle();
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_valid", issue_valid, 1'b0);
    check("async_rst_cnt", perf_issue_cnt, 32'd0);
    check("async_rst_robid", issue_robid, 7'h00);
    check("async_rst_issuing", issuing, 8'h00);
    mvalid = 1'b0;
    mcnt = 32'd0;
    sb_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_ents();
    issue_ready = 1'b1;

    // Streaming: five ready entries drain in age order back to back.
    for (int k = 0; k < 5; k++) set_ent(k, 1'b1, RW'(16 + k));
    for (int k = 0; k < 6; k++) begin
      exp_iss = (k < 5) ? (8'd1 << k) : 8'd0;
      #1;
      check("stream_issuing", issuing, exp_iss);
      cycle();
    end
    check("stream_cnt", perf_issue_cnt, 32'd5);
    check("stream_valid", issue_valid, 1'b0);
    check("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
